// File: rtl/pong_ai_paddle_driver.sv
// AI opponent for pong: waits a reaction delay, then steers the paddle
// toward the ball, or recentres the paddle while the ball moves away.
//
// Ports:
//   clock      - system clock
//   reset_n    - synchronous active-low reset
//   enable     - AI opponent active
//   ball_y     - ball row in game units
//   ball_dir_x - 1 when the ball is heading toward the AI paddle
//   paddle_y   - current top row of the AI paddle (feedback)
//   up, down   - registered move requests to the paddle controller
//   state      - registered FSM state (debug)
module pong_ai_paddle_driver #(
  parameter int PADDLE_HEIGHT  = 6,
  parameter int GAME_HEIGHT    = 30,
  parameter int REACTION_TICKS = 2500000,
  parameter int DEAD_ZONE      = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] ball_y,
  input  logic       ball_dir_x,
  input  logic [5:0] paddle_y,
  output logic       up,
  output logic       down,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    TRACK  = 2'd2,
    CENTER = 2'd3
  } state_t;

  localparam int CW =
    (REACTION_TICKS > 1) ? $clog2(REACTION_TICKS) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(REACTION_TICKS - 1);

  localparam logic [6:0] HALF_H =
    7'(PADDLE_HEIGHT / 2);

  localparam logic [6:0] MID_ROW =
    7'(GAME_HEIGHT / 2 - 1);

  localparam logic [6:0] DZ =
    7'(DEAD_ZONE);

  localparam logic [5:0] BOTTOM =
    6'(GAME_HEIGHT - PADDLE_HEIGHT - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          cnt_done;

  logic          up_d;
  logic          down_d;
  logic          steer;
  logic [6:0]    target;
  logic [6:0]    center;
  logic          want_up;
  logic          want_down;

  assign cnt_done = (cnt_q == CNT_LAST);

  // State register, counter and output registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      up      <= 1'b0;
      down    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      up      <= up_d;
      down    <= down_d;
    end
  end

  assign state = state_q;

  // Next-state logic; enable low overrides every transition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ball_dir_x ? WAIT : CENTER;
        end
        WAIT: begin
          if (!ball_dir_x)
            state_d = CENTER;
          else if (cnt_done)
            state_d = TRACK;
        end
        TRACK: begin
          if (!ball_dir_x)
            state_d = CENTER;
        end
        CENTER: begin
          if (ball_dir_x)
            state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Reaction counter: cleared on any entry to WAIT, counts while
  // staying in WAIT and holds at its last value instead of wrapping.
  always_comb begin
    cnt_d = '0;
    if (state_d == WAIT && state_q == WAIT) begin
      if (cnt_done)
        cnt_d = cnt_q;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  // Targeting. Widened to 7 bits so no sum can wrap.
  assign center = {1'b0, paddle_y} + HALF_H;

  always_comb begin
    steer  = 1'b0;
    target = '0;
    unique case (1'b1)
      (state_d == TRACK): begin
        steer  = 1'b1;
        target = {1'b0, ball_y};
      end
      (state_d == CENTER): begin
        steer  = 1'b1;
        target = MID_ROW;
      end
      default: begin
        steer  = 1'b0;
        target = '0;
      end
    endcase
  end

  assign want_down = (center + DZ) < target;
  assign want_up   = center > (target + DZ);

  // Move requests follow the state being entered, so the request
  // appears on the same edge as the state that issues it. The two
  // compares are mutually exclusive, and edge limits mask them.
  always_comb begin
    up_d   = 1'b0;
    down_d = 1'b0;
    if (steer) begin
      up_d   = want_up && (paddle_y != 6'd0);
      down_d = want_down && (paddle_y != BOTTOM);
    end
  end

endmodule

// File: tb/tb_pong_ai_paddle_driver.sv
// Directed testbench for pong_ai_paddle_driver
// with REACTION_TICKS=4 and DEAD_ZONE=1.
module tb_pong_ai_paddle_driver;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic [5:0] ball_y;
  logic       ball_dir_x;
  logic [5:0] paddle_y;
  logic       up;
  logic       down;
  logic [1:0] state;

  int checks;
  int errors;

  pong_ai_paddle_driver #(
    .PADDLE_HEIGHT(6),
    .GAME_HEIGHT(30),
    .REACTION_TICKS(4),
    .DEAD_ZONE(1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .ball_y(ball_y),
    .ball_dir_x(ball_dir_x),
    .paddle_y(paddle_y),
    .up(up),
    .down(down),
    .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock, sample 1 time unit after the edge and check
  // that up and down are never asserted together.
  task automatic tick();
    @(posedge clock);
    #1;
    checks++;
    if (up && down) begin
      errors++;
      $display("FAIL overlap: up=%0b down=%0b required not both 1",
               up, down);
    end
  endtask

  task automatic expect_out(input string name,
                            input logic [1:0] s,
                            input logic u,
                            input logic d);
    checks++;
    if ({state, up, down} !== {s, u, d}) begin
      errors++;
      $display("FAIL %s: state=%0d up=%0b down=%0b required state=%0d up=%0b down=%0b",
               name, state, up, down, s, u, d);
    end
  endtask

  task automatic go_idle();
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    enable     = 1'b1;
    ball_dir_x = 1'b1;
    ball_y     = 6'd25;
    paddle_y   = 6'd12;
    for (int i = 0; i < 2; i++) begin
      tick();
      expect_out("reset_hold", 2'd0, 1'b0, 1'b0);
    end
    reset_n = 1'b1;
    tick();
    expect_out("reset_release", 2'd1, 1'b0, 1'b0);
  endtask

  task automatic test_wait_track();
    go_idle();
    expect_out("idle", 2'd0, 1'b0, 1'b0);
    enable     = 1'b1;
    ball_dir_x = 1'b1;
    paddle_y   = 6'd12;
    ball_y     = 6'd25;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("wait_cycle", 2'd1, 1'b0, 1'b0);
    end
    tick();
    expect_out("track_down", 2'd2, 1'b0, 1'b1);
    ball_y = 6'd16;
    tick();
    expect_out("track_deadzone16", 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_dead_zone();
    // paddle_y=12 puts the centre at 15
    paddle_y = 6'd12;
    ball_y   = 6'd17;
    tick();
    expect_out("dz_down17", 2'd2, 1'b0, 1'b1);
    ball_y = 6'd14;
    tick();
    expect_out("dz_none14", 2'd2, 1'b0, 1'b0);
    ball_y = 6'd13;
    tick();
    expect_out("dz_up13", 2'd2, 1'b1, 1'b0);
  endtask

  task automatic test_top_limit();
    paddle_y = 6'd12;
    ball_y   = 6'd3;
    tick();
    expect_out("track_up", 2'd2, 1'b1, 1'b0);
    paddle_y = 6'd0;
    tick();
    expect_out("top_y3", 2'd2, 1'b0, 1'b0);
    ball_y = 6'd0;
    tick();
    expect_out("top_suppress", 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_bottom_limit();
    paddle_y = 6'd23;
    ball_y   = 6'd29;
    tick();
    expect_out("bottom_suppress", 2'd2, 1'b0, 1'b0);
    paddle_y = 6'd22;
    tick();
    expect_out("bottom_minus1", 2'd2, 1'b0, 1'b1);
  endtask

  task automatic test_center();
    go_idle();
    enable     = 1'b1;
    ball_dir_x = 1'b1;
    paddle_y   = 6'd20;
    ball_y     = 6'd5;
    tick();
    expect_out("center_wait", 2'd1, 1'b0, 1'b0);
    tick();
    ball_dir_x = 1'b0;
    tick();
    expect_out("center_up20", 2'd3, 1'b1, 1'b0);
    paddle_y = 6'd13;
    tick();
    expect_out("center_up13", 2'd3, 1'b1, 1'b0);
    paddle_y = 6'd12;
    tick();
    expect_out("center_hold12", 2'd3, 1'b0, 1'b0);
    paddle_y = 6'd5;
    tick();
    expect_out("center_down5", 2'd3, 1'b0, 1'b1);
    ball_dir_x = 1'b1;
    tick();
    expect_out("center_to_wait", 2'd1, 1'b0, 1'b0);
  endtask

  task automatic test_complete_vs_fall();
    go_idle();
    enable     = 1'b1;
    ball_dir_x = 1'b1;
    paddle_y   = 6'd12;
    ball_y     = 6'd15;
    for (int i = 0; i < 4; i++)
      tick();
    expect_out("wait_last", 2'd1, 1'b0, 1'b0);
    ball_dir_x = 1'b0;
    tick();
    expect_out("fall_wins", 2'd3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    go_idle();
    enable     = 1'b1;
    ball_dir_x = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    expect_out("reset_mid_wait", 2'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_out("restart_wait", 2'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      tick();
    expect_out("restart_full", 2'd1, 1'b0, 1'b0);
    tick();
    expect_out("restart_track", 2'd2, 1'b0, 1'b0);
  endtask

  task automatic test_disable();
    paddle_y = 6'd12;
    ball_y   = 6'd25;
    tick();
    expect_out("pre_disable", 2'd2, 1'b0, 1'b1);
    enable = 1'b0;
    tick();
    expect_out("disable", 2'd0, 1'b0, 1'b0);
    tick();
    expect_out("disable_hold", 2'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    enable     = 1'b0;
    ball_y     = '0;
    ball_dir_x = 1'b0;
    paddle_y   = '0;
    test_reset();
    test_wait_track();
    test_dead_zone();
    test_top_limit();
    test_bottom_limit();
    test_center();
    test_complete_vs_fall();
    test_reset_mid_wait();
    test_disable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_ai_paddle_driver.md
PONG_AI_PADDLE_DRIVER -- requirements
Module: pong_ai_paddle_driver

Interface
REQ-001 The module SHALL have parameter PADDLE_HEIGHT, default 6, paddle height in game units.
REQ-002 The module SHALL have parameter GAME_HEIGHT, default 30, board height in game units.
REQ-003 The module SHALL have parameter REACTION_TICKS, default 2500000, reaction delay in clocks (100 ms at 25 MHz).
REQ-004 The module SHALL have parameter DEAD_ZONE, default 1, the tolerance band in game units within which no move is requested.
REQ-005 The module SHALL have port clock, input, 1 bit: the single system clock.
REQ-006 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The module SHALL have port enable, input, 1 bit: AI opponent active.
REQ-008 The module SHALL have port ball_y, input, 6 bits: ball row in game units.
REQ-009 The module SHALL have port ball_dir_x, input, 1 bit: 1 means the ball is moving toward the AI paddle.
REQ-010 The module SHALL have port paddle_y, input, 6 bits: current top row of the AI paddle, fed back from the paddle controller.
REQ-011 The module SHALL have port up, output, 1 bit, registered: move-up request driven into the paddle controller.
REQ-012 The module SHALL have port down, output, 1 bit, registered: move-down request driven into the paddle controller.
REQ-013 The module SHALL have port state, output, 2 bits, registered: FSM state, provided for debug.

Function
REQ-014 The FSM SHALL have states IDLE=0, WAIT=1, TRACK=2 and CENTER=3.
REQ-015 In IDLE the module SHALL drive up=down=0. When enable=1, the next state SHALL be WAIT if ball_dir_x=1, else CENTER.
REQ-016 On entry to WAIT, the reaction counter SHALL clear to 0.
REQ-017 In WAIT, the counter SHALL increment every clock and drive up=down=0; when the counter equals REACTION_TICKS-1, the next state SHALL be TRACK.
REQ-018 In TRACK, target SHALL be ball_y.
REQ-019 In CENTER, target SHALL be GAME_HEIGHT/2-1.
REQ-020 Paddle center SHALL be paddle_y+PADDLE_HEIGHT/2, and all compares SHALL use 7-bit unsigned arithmetic so no sum wraps.
REQ-021 In TRACK or CENTER, the module SHALL assert down when center+DEAD_ZONE < target, assert up when center > target+DEAD_ZONE, and otherwise drive neither.
REQ-022 up SHALL be suppressed when paddle_y==0, and down SHALL be suppressed when paddle_y==GAME_HEIGHT-PADDLE_HEIGHT-1.
REQ-023 up and down SHALL never be 1 in the same cycle.
REQ-024 up and down SHALL be registered, with a latency of 1 clock from input change to output change.
REQ-025 In WAIT or TRACK, ball_dir_x=0 SHALL cause the next state to be CENTER.
REQ-026 In CENTER, ball_dir_x=1 SHALL cause the next state to be WAIT, so a rising ball_dir_x always restarts the reaction delay.
REQ-027 enable=0 in any state SHALL cause the next state to be IDLE and up=down=0 on the following cycle; enable=0 SHALL take priority over all other transitions.
REQ-028 When the counter completes and ball_dir_x falls in the same cycle, CENTER SHALL win.
REQ-029 The counter SHALL be wide enough to hold REACTION_TICKS-1 and SHALL never wrap.

Reset
REQ-030 When reset_n=0 at a rising clock edge, the module SHALL set state=IDLE, up=0, down=0 and counter=0, overriding all other inputs.
REQ-031 Reset asserted mid-WAIT or mid-TRACK SHALL abandon the operation, and the module SHALL restart from IDLE after release.
REQ-032 The module SHALL have no asynchronous behaviour.

Verification
Directed scenarios below use REACTION_TICKS=4, DEAD_ZONE=1 and the other parameters at default.
REQ-033 The bench SHALL cover: reset_n=0 for 2 clocks with enable=1 and ball_dir_x=1 -> state=0, up=down=0 throughout; then release -> state=1 one clock later.
REQ-034 The bench SHALL cover: enable=1, ball_dir_x=1, paddle_y=12, ball_y=25 -> 4 clocks in WAIT with up=down=0; then state=2 and down=1 one clock later; ball_y=16 -> down=0 and up=0.
REQ-035 The bench SHALL cover: in TRACK with paddle_y=12 and ball_y=3 -> up=1; then paddle_y=0 -> up=0 on the next clock.
REQ-036 The bench SHALL cover: in TRACK with paddle_y=23 and ball_y=29 -> down=0 (bottom limit).
REQ-037 The bench SHALL cover: ball_dir_x 1->0 during WAIT -> state=3; with paddle_y=20 -> up=1 until paddle center is within 1 of 14.
REQ-038 The bench SHALL cover: enable 1->0 while down=1 -> state=0 and down=0 one clock later; no cycle anywhere has up=down=1.
